div_share_sched: RTL and testbench

- Scheduler that shares one iterative unsigned divider among NREQ HLSM-style controllers, which would otherwise each build a combinational "a / b".
- Requesters raise Req with operands. The block grants round-robin, sequences a one-bit-per-cycle restoring division, and returns quotient/remainder with a one-cycle Valid pulse to the granted requester.
- Sits between the generated state machines and the single divider resource.

---
 rtl/div_share_pkg.sv | 16 +
 rtl/div_seq_core.sv | 57 +++++
 rtl/div_share_sched.sv | 108 ++++++++++
 tb/tb_div_share_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_share_pkg.sv
// Shared types and helpers for the shared-divider scheduler.
package div_share_pkg;

    localparam int DEF_DATAWIDTH = 64;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Ceiling log2, never below 1 so single-bit counters stay legal.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/div_seq_core.sv
// Restoring unsigned divider, one quotient bit per clock, MSB first.
module div_seq_core
    import div_share_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] dividend,
    input  logic [DATAWIDTH-1:0] divisor,
    output logic                 done,
    output logic [DATAWIDTH-1:0] quot,
    output logic [DATAWIDTH-1:0] rem
);

    localparam int CW = clog2(DATAWIDTH);

    // a_q shifts the dividend out at the top while quotient bits enter at the bottom
    logic [DATAWIDTH-1:0] a_q, b_q, r_q;
    logic [CW-1:0]        cnt_q;
    logic                 run_q;
    logic [DATAWIDTH:0]   trial, diff;

    assign trial = {r_q, a_q[DATAWIDTH-1]};
    assign diff  = trial - {1'b0, b_q};
    assign done  = run_q && (cnt_q == CW'(DATAWIDTH - 1));
    assign quot  = a_q;
    assign rem   = r_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            a_q   <= dividend;
            b_q   <= divisor;
            r_q   <= '0;
            cnt_q <= '0;
            run_q <= (divisor != '0);
        end else if (run_q) begin
            if (!diff[DATAWIDTH]) begin
                r_q <= diff[DATAWIDTH-1:0];
                a_q <= {a_q[DATAWIDTH-2:0], 1'b1};
            end else begin
                r_q <= trial[DATAWIDTH-1:0];
                a_q <= {a_q[DATAWIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q + 1'b1;
            if (done) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one iterative divider among NREQ requesters.
module div_share_sched
    import div_share_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           Req,
    input  logic [NREQ*DATAWIDTH-1:0] Dividend,
    input  logic [NREQ*DATAWIDTH-1:0] Divisor,
    output logic [NREQ-1:0]           Gnt,
    output logic [NREQ-1:0]           Valid,
    output logic [DATAWIDTH-1:0]      Quot,
    output logic [DATAWIDTH-1:0]      Rem,
    output logic                      DivZero,
    output logic                      Busy
);

    localparam int PW = clog2(NREQ);

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, own_q, win, ptr_nxt;
    logic [PW:0]          win_sum;
    logic [2*NREQ-1:0]    rot;
    logic                 any, dz_q, start;
    logic [DATAWIDTH-1:0] cur_a, cur_b, core_quot, core_rem;
    logic                 core_done;

    // Rotate so bit 0 is the pointer position; first set bit wins.
    assign rot = {Req, Req} >> ptr_q;

    always_comb begin
        any     = 1'b0;
        win_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && rot[k]) begin
                any     = 1'b1;
                win_sum = {1'b0, ptr_q} + (PW+1)'(k);
            end
        end
        if (win_sum >= (PW+1)'(NREQ)) win_sum = win_sum - (PW+1)'(NREQ);
    end

    assign win     = win_sum[PW-1:0];
    assign ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    assign cur_a   = Dividend[win*DATAWIDTH +: DATAWIDTH];
    assign cur_b   = Divisor[win*DATAWIDTH +: DATAWIDTH];
    assign Busy    = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: if (any) begin
                start   = 1'b1;
                state_d = (cur_b == '0) ? DONE : RUN;
            end
            RUN:  if (core_done) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            dz_q    <= 1'b0;
            Gnt     <= '0;
            Valid   <= '0;
            Quot    <= '0;
            Rem     <= '0;
            DivZero <= 1'b0;
        end else begin
            state_q <= state_d;
            Gnt     <= '0;
            Valid   <= '0;
            if (state_q == IDLE && any) begin
                Gnt   <= NREQ'(1) << win;
                ptr_q <= ptr_nxt;
                own_q <= win;
                dz_q  <= (cur_b == '0);
            end
            if (state_q == DONE) begin
                Valid   <= NREQ'(1) << own_q;
                DivZero <= dz_q;
                // On a zero divisor the core never iterates, so its quot still holds the dividend
                Quot    <= dz_q ? '1 : core_quot;
                Rem     <= dz_q ? core_quot : core_rem;
            end
        end
    end

    div_seq_core #(.DATAWIDTH(DATAWIDTH)) u_core (
        .Clk      (Clk),
        .Rst      (Rst),
        .start    (start),
        .dividend (cur_a),
        .divisor  (cur_b),
        .done     (core_done),
        .quot     (core_quot),
        .rem      (core_rem)
    );

endmodule

// File: tb/tb_div_share_sched.sv
// Scoreboard bench for div_share_sched with NREQ=3, DATAWIDTH=8.
module tb_div_share_sched;

    localparam int NREQ = 3;
    localparam int DW   = 8;

    logic                 Clk = 1'b0;
    logic                 Rst;
    logic [NREQ-1:0]      Req, Gnt, Valid;
    logic [NREQ*DW-1:0]   Dividend, Divisor;
    logic [DW-1:0]        Quot, Rem;
    logic                 DivZero, Busy;

    typedef struct {
        int          idx;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    div_share_sched #(.NREQ(NREQ), .DATAWIDTH(DW)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Dividend(Dividend), .Divisor(Divisor),
        .Gnt(Gnt), .Valid(Valid), .Quot(Quot), .Rem(Rem), .DivZero(DivZero), .Busy(Busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Monitor: every Valid must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (Rst === 1'b0 && Valid !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'(Valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("valid_onehot", 64'(Valid), 64'(1 << e.idx));
                check("quot", 64'(Quot), 64'(e.q));
                check("rem", 64'(Rem), 64'(e.r));
                check("divzero", 64'(DivZero), 64'(e.dz));
                check("valid_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        Dividend[i*DW +: DW] = a;
        Divisor[i*DW +: DW]  = b;
    endtask

    task automatic wait_gnt(output int c, output logic [NREQ-1:0] g);
        g = '0;
        c = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge Clk);
            if (Gnt != '0) begin
                g = Gnt;
                c = cyc;
                return;
            end
        end
        timeout("gnt_wait");
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0) return;
            @(negedge Clk);
        end
        timeout("drain");
    endtask

    task automatic push(input int i, input logic [DW-1:0] q, input logic [DW-1:0] r,
                        input logic dz, input int c);
        sb.push_back('{i, q, r, dz, c + (dz ? 1 : DW + 1)});
    endtask

    task automatic run_one(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] q, input logic [DW-1:0] r, input logic dz);
        int c;
        logic [NREQ-1:0] g;
        @(negedge Clk);
        set_op(i, a, b);
        Req[i] = 1'b1;
        wait_gnt(c, g);
        Req = '0;
        check("gnt", 64'(g), 64'(1 << i));
        push(i, q, r, dz, c);
        drain();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, 64'(Gnt), 64'd0);
        check({tag, "_valid"}, 64'(Valid), 64'd0);
        check({tag, "_quot"}, 64'(Quot), 64'd0);
        check({tag, "_rem"}, 64'(Rem), 64'd0);
        check({tag, "_divzero"}, 64'(DivZero), 64'd0);
        check({tag, "_busy"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, prev, seen;
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] rr_exp [4];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

        Rst = 1'b1;
        Req = '0;
        Dividend = '0;
        Divisor = '0;
        repeat (2) @(negedge Clk);
        check_idle_outputs("reset");
        Rst = 1'b0;

        // Basic, boundaries, divide by zero then recovery
        run_one(0, 8'd200, 8'd7,   8'd28,  8'd4,  1'b0);
        run_one(1, 8'd255, 8'd1,   8'd255, 8'd0,  1'b0);
        run_one(2, 8'd5,   8'd9,   8'd0,   8'd5,  1'b0);
        run_one(0, 8'd255, 8'd255, 8'd1,   8'd0,  1'b0);
        run_one(1, 8'd13,  8'd0,   8'd255, 8'd13, 1'b1);
        run_one(1, 8'd13,  8'd2,   8'd6,   8'd1,  1'b0);

        // Round-robin with all requests held
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        set_op(0, 8'd100, 8'd3);
        set_op(1, 8'd77,  8'd10);
        set_op(2, 8'd250, 8'd16);
        Req = 3'b111;
        prev = 0;
        for (int n = 0; n < 4; n++) begin
            wait_gnt(c, g);
            if (n == 3) Req = '0;
            check("rr_gnt", 64'(g), 64'(rr_exp[n]));
            if (n > 0) check("rr_spacing", 64'(c - prev), 64'd10);
            prev = c;
            case (rr_exp[n])
                3'b001:  push(0, 8'd33, 8'd1,  1'b0, c);
                3'b010:  push(1, 8'd7,  8'd7,  1'b0, c);
                default: push(2, 8'd15, 8'd10, 1'b0, c);
            endcase
        end
        drain();

        // Withdrawal: Req[1] pulsed only while requester 0 is in progress
        @(negedge Clk);
        set_op(0, 8'd200, 8'd7);
        Req = 3'b001;
        wait_gnt(c, g);
        Req = '0;
        check("wd_gnt", 64'(g), 64'd1);
        push(0, 8'd28, 8'd4, 1'b0, c);
        repeat (2) @(negedge Clk);
        Req[1] = 1'b1;
        repeat (3) @(negedge Clk);
        Req[1] = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (Gnt[1] || Valid[1]) seen++;
        end
        check("wd_no_req1", 64'(seen), 64'd0);
        drain();

        // Reset during a run for requester 1 (pointer would otherwise move to 2)
        @(negedge Clk);
        set_op(1, 8'd55, 8'd5);
        Req = 3'b010;
        wait_gnt(c, g);
        Req = '0;
        check("mr_gnt", 64'(g), 64'd2);
        repeat (4) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check_idle_outputs("midreset");
        repeat (12) @(negedge Clk);
        set_op(1, 8'd60, 8'd7);
        set_op(2, 8'd99, 8'd10);
        Req = 3'b110;
        wait_gnt(c, g);
        Req = 3'b100;
        check("mr_first_gnt", 64'(g), 64'd2);
        push(1, 8'd8, 8'd4, 1'b0, c);
        wait_gnt(c, g);
        Req = '0;
        check("mr_second_gnt", 64'(g), 64'd4);
        push(2, 8'd9, 8'd9, 1'b0, c);
        drain();
        repeat (5) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
